// File: rtl/music_reader.sv
// rtl/music_reader.sv - paced sequential reader for the music sample ROM with valid/ready output
// Build option: define MUSIC_READER_LOOP_EN to wrap at the end of the track instead of stopping.
module music_reader #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 17,
   parameter int DEPTH    = 54832,
   parameter int TICK_DIV = 3125
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              playing,
   output logic              done,
   output logic              underrun
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      FETCH,
      CAPTURE,
      PRESENT
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] sample_q;
   logic              valid_q;
   logic              done_q;
   logic              underrun_q;
   logic              tick;
`ifndef MUSIC_READER_LOOP_EN
   logic              last_q;
`endif

   assign tick   = (state_q != IDLE) && (cnt_q == CNT_W'(TICK_DIV - 1));
   assign cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
   // Wrap at the last populated word, not at the top of the address space.
   assign addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
`ifndef MUSIC_READER_LOOP_EN
         last_q     <= 1'b0;
`endif
      end else begin
         done_q     <= 1'b0;
         underrun_q <= tick && (state_q == PRESENT);
         cnt_q      <= (state_q == IDLE) ? '0 : cnt_d;
         if (stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (play) state_q <= WAIT_TICK;
               end
               WAIT_TICK: begin
                  if (tick && !pause) state_q <= FETCH;
               end
               FETCH: begin
                  state_q <= CAPTURE;
               end
               CAPTURE: begin
                  sample_q <= rom_data;
                  valid_q  <= 1'b1;
`ifndef MUSIC_READER_LOOP_EN
                  last_q   <= (addr_q == ADDR_W'(DEPTH - 1));
`endif
                  addr_q   <= addr_d;
                  state_q  <= PRESENT;
               end
               PRESENT: begin
                  if (sample_ready) begin
                     valid_q <= 1'b0;
`ifdef MUSIC_READER_LOOP_EN
                     state_q <= WAIT_TICK;
`else
                     if (last_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= WAIT_TICK;
                     end
`endif
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rom_addr     = addr_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign playing      = (state_q != IDLE);
   assign done         = done_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_music_reader.sv
// tb/tb_music_reader.sv - table and scoreboard bench for music_reader (TICK_DIV=8, DEPTH=4)
module tb_music_reader;

   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 17;
   localparam int DEPTH    = 4;
   localparam int TICK_DIV = 8;

   logic              Clk;
   logic              Reset_n;
   logic              play, pause, stop, sample_ready;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] sample;
   logic              sample_valid, playing, done, underrun;

   music_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .play(play), .pause(pause), .stop(stop),
      .rom_addr(rom_addr), .rom_data(rom_data), .sample(sample),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .playing(playing), .done(done), .underrun(underrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Registered ROM: word k = k + 0x100
   always @(posedge Clk) rom_data <= DATA_W'(rom_addr) + 17'h100;

   typedef struct {
      logic              pl, pa, st, rd;
      int                n;
      logic              e_playing, e_valid, e_done;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_sample;
   } vec_t;

   vec_t              vecs[11];
   logic [DATA_W-1:0] sb[$];
   int                checks = 0;
   int                errors = 0;
   int                und_cnt = 0;
   int                done_cnt = 0;
   logic              prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // One clock, sampled on the falling edge; new presentations are scored here.
   task automatic cyc();
      logic [DATA_W-1:0] e;
      @(negedge Clk);
      if (underrun) und_cnt++;
      if (done) done_cnt++;
      if (sample_valid && !prev_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got %h want none", sample);
         end else begin
            e = sb.pop_front();
            if (sample !== e) begin
               errors++;
               $display("FAIL sb_sample got %h want %h", sample, e);
            end
         end
      end
      prev_valid = sample_valid;
   endtask

   task automatic wait_valid(input int limit, input string name);
      int k;
      k = 0;
      while (!sample_valid && k < limit) begin
         cyc();
         k++;
      end
      checks++;
      if (!sample_valid) begin
         errors++;
         $display("FAIL %s timeout got valid=0 want valid=1", name);
      end
   endtask

   task automatic setv(input int i, input logic pl, pa, st, rd, input int n,
                       input logic epl, ev, ed, input logic [ADDR_W-1:0] ea,
                       input logic [DATA_W-1:0] es);
      vecs[i].pl = pl; vecs[i].pa = pa; vecs[i].st = st; vecs[i].rd = rd; vecs[i].n = n;
      vecs[i].e_playing = epl; vecs[i].e_valid = ev; vecs[i].e_done = ed;
      vecs[i].e_addr = ea; vecs[i].e_sample = es;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int vcnt;
      logic [DATA_W-1:0] last_s;
      // Cycle P1 is the first edge that sees play=1; ticks land at P8, P16, ...
      setv(0, 0,0,0,1, 1, 0,0,0, 0, 17'h000);
      setv(1, 1,0,0,1, 1, 1,0,0, 0, 17'h000);
      setv(2, 1,0,0,1, 9, 1,0,0, 0, 17'h000);
      setv(3, 1,0,0,1, 1, 1,1,0, 1, 17'h100);
      setv(4, 1,0,0,1, 1, 1,0,0, 1, 17'h100);
      setv(5, 1,0,0,1, 7, 1,1,0, 2, 17'h101);
      setv(6, 1,0,0,1, 8, 1,1,0, 3, 17'h102);
      setv(7, 1,0,0,1, 8, 1,1,0, 0, 17'h103);
`ifdef MUSIC_READER_LOOP_EN
      setv(8, 0,0,0,1, 1, 1,0,0, 0, 17'h103);
      setv(9, 0,0,0,1, 7, 1,1,0, 1, 17'h100);
      last_s = 17'h100;
`else
      setv(8, 0,0,0,1, 1, 0,0,1, 0, 17'h103);
      setv(9, 0,0,0,1, 1, 0,0,0, 0, 17'h103);
      last_s = 17'h103;
`endif
      setv(10, 0,0,1,1, 1, 0,0,0, 0, last_s);

      Reset_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; sample_ready = 1'b1;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;

      sb.push_back(17'h100); sb.push_back(17'h101);
      sb.push_back(17'h102); sb.push_back(17'h103);
`ifdef MUSIC_READER_LOOP_EN
      sb.push_back(17'h100);
`endif
      for (int i = 0; i < 11; i++) begin
         play = vecs[i].pl; pause = vecs[i].pa; stop = vecs[i].st; sample_ready = vecs[i].rd;
         repeat (vecs[i].n) cyc();
         chk($sformatf("v%0d_playing", i), 32'(playing), 32'(vecs[i].e_playing));
         chk($sformatf("v%0d_valid", i), 32'(sample_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
         chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d_sample", i), 32'(sample), 32'(vecs[i].e_sample));
         chk($sformatf("v%0d_underrun", i), 32'(underrun), 32'd0);
      end

      // Downstream stalls for 20 cycles: two dropped ticks, no address skip
      stop = 1'b0; sample_ready = 1'b0; play = 1'b1;
      sb.push_back(17'h100); sb.push_back(17'h101);
      wait_valid(30, "ur_first");
      und_cnt = 0;
      repeat (20) cyc();
      chk("ur_count", 32'(und_cnt), 32'd2);
      chk("ur_sample_hold", 32'(sample), 32'h100);
      chk("ur_addr", 32'(rom_addr), 32'd1);
      chk("ur_valid_hold", 32'(sample_valid), 32'd1);
      sample_ready = 1'b1;
      cyc();
      chk("ur_accept", 32'(sample_valid), 32'd0);
      wait_valid(30, "ur_next");
      chk("ur_next_sample", 32'(sample), 32'h101);
      chk("ur_next_addr", 32'(rom_addr), 32'd2);
      stop = 1'b1; play = 1'b0;
      cyc();
      stop = 1'b0;

      // Pause across three tick periods while waiting for a tick
      play = 1'b1;
      sb.push_back(17'h100); sb.push_back(17'h101);
      wait_valid(30, "pz_first");
      cyc();
      pause = 1'b1;
      vcnt = 0;
      repeat (24) begin
         cyc();
         if (sample_valid) vcnt++;
      end
      chk("pz_no_fetch", 32'(vcnt), 32'd0);
      chk("pz_addr", 32'(rom_addr), 32'd1);
      chk("pz_playing", 32'(playing), 32'd1);
      pause = 1'b0;
      wait_valid(30, "pz_resume");
      chk("pz_resume_sample", 32'(sample), 32'h101);
      stop = 1'b1; play = 1'b0;
      cyc();
      stop = 1'b0;

      // Stop during CAPTURE aborts the read and rewinds
      play = 1'b1;
      repeat (10) cyc();
      stop = 1'b1;
      cyc();
      chk("st_playing", 32'(playing), 32'd0);
      chk("st_valid", 32'(sample_valid), 32'd0);
      chk("st_addr", 32'(rom_addr), 32'd0);
      chk("st_done", 32'(done), 32'd0);
      chk("st_sample_keep", 32'(sample), 32'h101);
      stop = 1'b0;
      sb.push_back(17'h100);
      wait_valid(30, "st_restart");
      chk("st_restart_sample", 32'(sample), 32'h100);

      // Asynchronous reset while a sample is being presented
      sample_ready = 1'b0; play = 1'b0;
      Reset_n = 1'b0;
      #1;
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      Reset_n = 1'b1;
      cyc();
      chk("rst_stays_idle", 32'(playing), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef MUSIC_READER_LOOP_EN
      chk("done_total", 32'(done_cnt), 32'd0);
`else
      chk("done_total", 32'(done_cnt), 32'd1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/music_reader.md
Name: music_reader

Overview:
- Read-side engine for the registered 1-cycle music sample ROM (17-bit address, 17-bit data, 54832 words).
- Paces ROM reads at the audio sample rate with a tick divider and walks the address space sequentially.
- Absorbs the ROM read latency and presents each sample on a valid/ready interface to the downstream audio serializer.
- Provides play, pause and stop control, plus end-of-track and underrun status.

Parameters:
- ADDR_W, 17, ROM address width
- DATA_W, 17, sample width
- DEPTH, 54832, number of valid ROM words; last address is DEPTH-1
- TICK_DIV, 3125, Clk cycles per sample tick (50 MHz / 16 kHz); must be >= 4

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- play  in  1  level; start or resume playback
- pause  in  1  level; freeze playback while high
- stop  in  1  level; abort and rewind to address 0
- rom_addr  out  ADDR_W  address to the sample ROM
- rom_data  in  DATA_W  ROM output; valid one Clk after rom_addr is sampled
- sample  out  DATA_W  current sample to the downstream block
- sample_valid  out  1  sample holds valid data
- sample_ready  in  1  downstream accepts the sample on this edge
- playing  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of track (non-loop build only)
- underrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, rom_addr=0, sample=0, sample_valid=0, done=0, underrun=0, tick counter=0.
- Tick counter runs only outside IDLE; counts 0..TICK_DIV-1.
  - tick=1 for the single cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - Counter is cleared on entry to IDLE.
- States: IDLE, WAIT_TICK, FETCH, CAPTURE, PRESENT.
  - IDLE: on play=1 and stop=0 -> WAIT_TICK.
  - WAIT_TICK: on tick and pause=0 -> FETCH. While pause=1, ticks are ignored and rom_addr holds.
  - FETCH: rom_addr is stable and the ROM samples it at the end of this cycle. -> CAPTURE unconditionally.
  - CAPTURE: sample<=rom_data and sample_valid<=1. rom_addr advances: +1, or 0 if it equals DEPTH-1. -> PRESENT.
  - PRESENT: on sample_ready=1, sample_valid<=0.
    - Normally -> WAIT_TICK.
    - If the accepted sample came from address DEPTH-1 and this is a non-loop build -> IDLE, with done=1 for one cycle.
- Read latency: the first tick edge plus 2 cycles gives sample_valid=1 (tick edge -> FETCH -> CAPTURE -> valid).
- sample is stable whenever sample_valid=1; it changes only in CAPTURE.
- Underrun: a tick while in PRESENT, FETCH or CAPTURE is dropped.
  - underrun pulses 1 cycle only if the tick arrives in PRESENT.
  - No address skip; the tick counter keeps running.
- Control priority: stop > pause > play.
  - stop=1 in any state -> IDLE next edge; rom_addr=0, sample_valid=0; sample keeps its last value; no done pulse.
  - pause in FETCH or CAPTURE does not abort the in-flight read. The sample is still presented; pause takes effect in WAIT_TICK.
  - pause does not block the sample_ready handshake.
- play=0 outside IDLE has no effect; only stop ends playback early.
- Address wrap is computed at DEPTH-1, not at 2^ADDR_W-1.

Optional Feature:
- Macro: MUSIC_READER_LOOP_EN.
- Defined: after address DEPTH-1, rom_addr wraps to 0 and playback continues indefinitely. done is tied to 0.
- Undefined: after the DEPTH-1 sample is accepted, the block returns to IDLE with rom_addr=0 and pulses done. play must be re-asserted to restart; a play held high restarts on the next cycle after IDLE.

Test Plan:
- Reset mid-PRESENT (Reset_n low for 1 ns, asynchronous) -> sample_valid=0, rom_addr=0 and IDLE immediately, before the next edge.
- TICK_DIV=8, ROM word k = k+0x100, sample_ready tied 1, play=1 -> samples 0x100, 0x101, 0x102, … spaced 8 cycles apart; first sample_valid appears 2 cycles after the first tick.
- sample_ready held 0 for 20 cycles with TICK_DIV=8 -> underrun pulses twice, sample holds 0x100, rom_addr=1; after ready, the next sample is 0x101 (no skip).
- pause=1 for 3 tick periods during WAIT_TICK -> no FETCH; rom_addr is unchanged; resume yields the next sequential sample.
- DEPTH=4, non-loop build -> samples 0x100..0x103, done pulses 1 cycle after the 0x103 handshake, then IDLE. Loop build -> 0x100 follows 0x103 and done stays 0.
- stop=1 while in CAPTURE -> IDLE next edge, sample_valid=0, rom_addr=0, no done; play then restarts at 0x100.
